// File: rtl/set_assoc_read_cache.sv
// Read-only N-way set-associative blocking cache, word addressed; optional CACHE_PERF_CNT_EN adds hit/miss counters.
// Latency: a hit responds in the 2nd cycle after the accept cycle; a miss adds a burst refill of BLOCK_WORDS beats.
// Backpressure: req_ready only in IDLE; refill request held until mem_req_ready; refill beats may have gaps.
module set_assoc_read_cache #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int WAYS        = 4,
    parameter int SETS        = 64,
    parameter int BLOCK_WORDS = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              req_ready,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_hit,
    input  logic              flush,
    output logic              mem_req_valid,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_req_ready,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_resp_data,
    output logic [31:0]       hit_count,
    output logic [31:0]       miss_count
);
    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - OFF_W - IDX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_REFILL_REQ,
        S_REFILL_DATA,
        S_RESPOND
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0]               addr_q;
    logic [SETS-1:0][WAYS-1:0]       valid_q;
    logic [SETS-1:0][WAY_W-1:0]      rr_q;
    logic [WAY_W-1:0]                victim_q;
    logic                            victim_rr_q;
    logic [OFF_W-1:0]                beat_q;
    logic [DATA_W-1:0]               resp_data_q;
    logic                            resp_hit_q;

    logic [DATA_W-1:0] data_mem [WAYS][SETS][BLOCK_WORDS];
    logic [TAG_W-1:0]  tag_mem  [WAYS][SETS];

    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;

    assign tag = addr_q[ADDR_W-1 -: TAG_W];
    assign idx = addr_q[OFF_W +: IDX_W];
    assign off = addr_q[OFF_W-1:0];

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] rr_next;

    // Descending scan leaves the lowest-numbered matching/invalid way selected.
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && (tag_mem[w][idx] == tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        rr_next = (WAYS == 1) ? '0 : rr_q[idx] + WAY_W'(1);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        mem_req_valid = 1'b0;
        mem_req_addr  = '0;
        case (state_q)
            S_IDLE: begin
                req_ready = 1'b1;
                if (!flush && req_valid) begin
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_d = hit ? S_RESPOND : S_REFILL_REQ;
            end
            S_REFILL_REQ: begin
                mem_req_valid = 1'b1;
                mem_req_addr  = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (mem_req_ready) begin
                    state_d = S_REFILL_DATA;
                end
            end
            S_REFILL_DATA: begin
                if (mem_resp_valid && (beat_q == LAST_BEAT)) begin
                    state_d = S_RESPOND;
                end
            end
            S_RESPOND: begin
                resp_valid = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_q      <= '0;
            valid_q     <= '0;
            rr_q        <= '0;
            victim_q    <= '0;
            victim_rr_q <= 1'b0;
            beat_q      <= '0;
            resp_data_q <= '0;
            resp_hit_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (flush) begin
                        valid_q <= '0;
                    end else if (req_valid) begin
                        addr_q <= req_addr;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        resp_data_q <= data_mem[hit_way][idx][off];
                        resp_hit_q  <= 1'b1;
                    end else begin
                        victim_q    <= inv_found ? inv_way : rr_q[idx];
                        victim_rr_q <= !inv_found;
                        beat_q      <= '0;
                    end
                end
                S_REFILL_DATA: begin
                    if (mem_resp_valid) begin
                        beat_q <= beat_q + OFF_W'(1);
                        if (beat_q == off) begin
                            resp_data_q <= mem_resp_data;
                        end
                        if (beat_q == LAST_BEAT) begin
                            valid_q[idx][victim_q] <= 1'b1;
                            resp_hit_q             <= 1'b0;
                            if (victim_rr_q) begin
                                rr_q[idx] <= rr_next;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Beats land in the victim way as they arrive; the line only becomes visible once valid is set on the last beat.
    always_ff @(posedge clock) begin
        if ((state_q == S_REFILL_DATA) && mem_resp_valid) begin
            data_mem[victim_q][idx][beat_q] <= mem_resp_data;
            if (beat_q == LAST_BEAT) begin
                tag_mem[victim_q][idx] <= tag;
            end
        end
    end

    assign resp_data = resp_data_q;
    assign resp_hit  = resp_hit_q;

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_RESPOND) begin
            if (resp_hit_q) begin
                if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_q <= hit_cnt_q + 32'd1;
            end else begin
                if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_set_assoc_read_cache.sv
// Randomised bench for set_assoc_read_cache against a line-level model of sets, ways, tags and round-robin pointers.
module tb_set_assoc_read_cache;
    localparam int WAYS = 4;
    localparam int SETS = 64;
    localparam int BW   = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic [31:0] req_addr = '0;
    logic        req_ready;
    logic        resp_valid;
    logic [63:0] resp_data;
    logic        resp_hit;
    logic        flush = 1'b0;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready = 1'b0;
    logic        mem_resp_valid = 1'b0;
    logic [63:0] mem_resp_data = '0;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int n_checks = 0;
    int n_fail   = 0;

    set_assoc_read_cache #(.ADDR_W(32), .DATA_W(64), .WAYS(WAYS), .SETS(SETS), .BLOCK_WORDS(BW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit),
        .flush(flush),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clock = ~clock;

    // Reference model: per set, which tags are resident in which way, plus the replacement pointer.
    bit          m_valid [SETS][WAYS];
    logic [23:0] m_tag   [SETS][WAYS];
    int          m_rr    [SETS];
    int          m_hits;
    int          m_misses;

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if ((a >> 2) == 32'h40) return 64'hA0 + 64'(a % 4);
        return {a ^ 32'h5A5A_0000, ~a};
    endfunction

    function automatic int model_find(input logic [31:0] a);
        int s = int'((a / BW) % SETS);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w] && m_tag[s][w] == 24'(a / (BW * SETS))) return w;
        return -1;
    endfunction

    task automatic model_install(input logic [31:0] a);
        int s = int'((a / BW) % SETS);
        int v = -1;
        for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[s][w]) v = w;
        if (v < 0) begin
            v = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % WAYS;
        end
        m_valid[s][v] = 1'b1;
        m_tag[s][v]   = 24'(a / (BW * SETS));
    endtask

    task automatic model_flush();
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic model_reset();
        model_flush();
        for (int s = 0; s < SETS; s++) m_rr[s] = 0;
        m_hits = 0;
        m_misses = 0;
    endtask

    task automatic reset_dut();
        #1;
        reset = 1'b0;
        req_valid = 1'b0; flush = 1'b0; mem_req_ready = 1'b0; mem_resp_valid = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(posedge clock); #1;
    endtask

    // One read, with a memory responder: rdly cycles of mem_req_ready low, gap idle cycles between beats.
    // abort_after >= 0 returns once that many beats were consumed, leaving the refill in flight.
    task automatic do_read(input logic [31:0] a, input int rdly, input int gap, input int abort_after, input string nm);
        int          exp_way = model_find(a);
        bit          exp_hit = (exp_way >= 0);
        logic [63:0] exp_d = mem_word(a);
        logic [31:0] exp_blk = a & ~32'(BW - 1);
        logic [31:0] held = '0;
        bit          got = 1'b0, saw_req = 1'b0;
        int          phase = 0, cnt = 0, beat = 0, gapc = 0, cyc = 0, w = 0;
        while (!req_ready && w < 50) begin @(posedge clock); #1; w++; end
        req_valid = 1'b1;
        req_addr  = a;
        while (!got && cyc < 300) begin
            @(posedge clock); #1;
            cyc++;
            req_valid = 1'b0;
            if (resp_valid) begin
                got = 1'b1;
                n_checks++;
                if (resp_hit !== exp_hit) begin n_fail++; $display("FAIL %s hit addr=%h got=%b exp=%b", nm, a, resp_hit, exp_hit); end
                n_checks++;
                if (resp_data !== exp_d) begin n_fail++; $display("FAIL %s data addr=%h got=%h exp=%h", nm, a, resp_data, exp_d); end
                n_checks++;
                if (saw_req === exp_hit) begin n_fail++; $display("FAIL %s memreq addr=%h saw_req=%b exp=%b", nm, a, saw_req, !exp_hit); end
                if (exp_hit) begin
                    n_checks++;
                    if (cyc != 2) begin n_fail++; $display("FAIL %s hit_latency got=%0d exp=2", nm, cyc); end
                end
            end else begin
                if (phase == 0 && mem_req_valid) begin
                    saw_req = 1'b1;
                    held = mem_req_addr;
                    n_checks++;
                    if (mem_req_addr !== exp_blk) begin n_fail++; $display("FAIL %s mem_req_addr got=%h exp=%h", nm, mem_req_addr, exp_blk); end
                    cnt = rdly;
                    if (cnt == 0) begin mem_req_ready = 1'b1; phase = 2; end
                    else begin mem_resp_valid = 1'b1; mem_resp_data = 64'hDEAD; phase = 1; end
                end else if (phase == 1) begin
                    n_checks++;
                    if (!mem_req_valid || mem_req_addr !== held) begin
                        n_fail++; $display("FAIL %s req_hold vld=%b addr=%h exp=%h", nm, mem_req_valid, mem_req_addr, held);
                    end
                    cnt--;
                    if (cnt == 0) begin mem_req_ready = 1'b1; mem_resp_valid = 1'b0; phase = 2; end
                end else if (phase == 2) begin
                    mem_req_ready = 1'b0;
                    phase = 3; beat = 0; gapc = 0;
                end else if (phase == 3) begin
                    if (mem_resp_valid) begin
                        beat++;
                        mem_resp_valid = 1'b0;
                        gapc = gap;
                    end
                    if (beat == abort_after) return;
                    if (beat < BW) begin
                        if (gapc == 0) begin mem_resp_valid = 1'b1; mem_resp_data = mem_word(exp_blk + 32'(beat)); end
                        else gapc--;
                    end
                end
            end
        end
        mem_resp_valid = 1'b0;
        mem_req_ready = 1'b0;
        if (!got) begin
            n_fail++; $display("FAIL %s timeout addr=%h", nm, a);
            reset_dut();
            return;
        end
        if (exp_hit) m_hits++; else begin m_misses++; model_install(a); end
        @(posedge clock); #1;
        n_checks++;
        if (resp_valid !== 1'b0 || resp_data !== exp_d || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s pulse vld=%b data=%h rdy=%b exp_data=%h", nm, resp_valid, resp_data, req_ready, exp_d);
        end
    endtask

    task automatic check_idle_outputs(input string nm);
        n_checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_data !== 64'h0 || resp_hit !== 1'b0 ||
            mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
            n_fail++;
            $display("FAIL %s rdy=%b vld=%b data=%h hit=%b mvld=%b maddr=%h hc=%0d mc=%0d exp rdy=1 others=0", nm,
                     req_ready, resp_valid, resp_data, resp_hit, mem_req_valid, mem_req_addr, hit_count, miss_count);
        end
    endtask

    task automatic check_counters(input string nm);
        int eh, em;
`ifdef CACHE_PERF_CNT_EN
        eh = m_hits; em = m_misses;
`else
        eh = 0; em = 0;
`endif
        n_checks++;
        if (hit_count !== 32'(eh) || miss_count !== 32'(em)) begin
            n_fail++; $display("FAIL %s counters hit=%0d miss=%0d exp hit=%0d miss=%0d", nm, hit_count, miss_count, eh, em);
        end
    endtask

    task automatic test_reset();
        reset_dut();
        check_idle_outputs("reset");
    endtask

    task automatic test_cold_miss_hit();
        reset_dut();
        do_read(32'h101, 0, 0, -1, "cold_miss");
        do_read(32'h103, 0, 0, -1, "warm_hit");
        check_counters("cold_miss_hit");
    endtask

    task automatic test_eviction();
        reset_dut();
        for (int i = 0; i <= 4; i++) do_read(32'(i) * 32'h100, 0, 0, -1, "evict_fill");
        n_checks++;
        if (model_find(32'h000) != -1 || model_find(32'h400) != 0) begin
            n_fail++; $display("FAIL evict_model way_of_400=%0d exp=0", model_find(32'h400));
        end
        do_read(32'h100, 0, 0, -1, "evict_hit");
        do_read(32'h000, 0, 0, -1, "evict_miss");
    endtask

    task automatic test_backpressure();
        reset_dut();
        do_read(32'h2A6, 3, 2, -1, "bp_miss");
        do_read(32'h2A4, 0, 0, -1, "bp_hit0");
        do_read(32'h2A7, 0, 0, -1, "bp_hit3");
    endtask

    task automatic test_flush();
        reset_dut();
        do_read(32'h100, 0, 0, -1, "flush_fill");
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h100;
        @(posedge clock); #1;
        flush = 1'b0; req_valid = 1'b0;
        model_flush();
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_reject cyc=%0d rdy=%b vld=%b mvld=%b exp 1 0 0", i, req_ready, resp_valid, mem_req_valid);
            end
            @(posedge clock); #1;
        end
        do_read(32'h100, 1, 0, -1, "flush_miss");
        check_counters("flush");
    endtask

    task automatic test_reset_mid_refill();
        reset_dut();
        do_read(32'h100, 0, 1, 2, "abort");
        reset = 1'b0;
        mem_resp_valid = 1'b0; mem_req_ready = 1'b0;
        #2;
        check_idle_outputs("reset_mid_refill");
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        @(posedge clock); #1;
        do_read(32'h100, 0, 0, -1, "after_abort");
    endtask

    task automatic test_random();
        reset_dut();
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 14) == 0) begin
                flush = 1'b1;
                @(posedge clock); #1;
                flush = 1'b0;
                model_flush();
            end
            do_read(a, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), -1, "random");
        end
        check_counters("random");
    endtask

    initial begin
        test_reset();
        test_cold_miss_hit();
        test_eviction();
        test_backpressure();
        test_flush();
        test_reset_mid_refill();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
